// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI SRAM emulator: opcodes, FSM states and
// the command decoder.
package qspi_pkg;

    localparam logic [7:0] OP_READ       = 8'h03;
    localparam logic [7:0] OP_WRITE      = 8'h02;
    localparam logic [7:0] OP_FAST_READ  = 8'h0B;
    localparam logic [7:0] OP_QUAD_READ  = 8'hEB;
    localparam logic [7:0] OP_QUAD_WRITE = 8'h38;

    localparam int DUMMY_FAST = 8;

    typedef enum logic [3:0] {
        ST_COMMAND    = 4'd0,
        ST_ADDR       = 4'd1,
        ST_ADDR_QUAD  = 4'd2,
        ST_WAIT       = 4'd3,
        ST_READ       = 4'd4,
        ST_READ_QUAD  = 4'd5,
        ST_WRITE      = 4'd6,
        ST_WRITE_QUAD = 4'd7,
        ST_FAIL       = 4'd8
    } state_t;

    function automatic state_t decode_cmd(input logic [7:0] op);
        case (op)
            OP_READ, OP_WRITE, OP_FAST_READ: decode_cmd = ST_ADDR;
            OP_QUAD_READ, OP_QUAD_WRITE:     decode_cmd = ST_ADDR_QUAD;
            default:                         decode_cmd = ST_FAIL;
        endcase
    endfunction

endpackage

// File: rtl/qspi_sync.sv
// Brings sck, ss_n and the SIO pins into the clk domain and produces
// single-cycle sck rise/fall and ss_n rise strobes.
module qspi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sck,
    input  logic       i_ss_n,
    input  logic [3:0] i_sio,
    output logic       o_sck_rise,
    output logic       o_sck_fall,
    output logic       o_ss_n,
    output logic       o_ss_rise,
    output logic [3:0] o_sio
);

    logic [SYNC_STAGES-1:0]      r_sck_sync;
    logic [SYNC_STAGES-1:0]      r_ss_sync;
    logic [SYNC_STAGES-1:0][3:0] r_sio_sync;
    logic                        r_sck_d;
    logic                        r_ss_d;

    // Synchronizer chains plus one-cycle history for edge detection; idle is sck low, ss_n high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_sync <= '0;
            r_ss_sync  <= '1;
            r_sio_sync <= '0;
            r_sck_d    <= 1'b0;
            r_ss_d     <= 1'b1;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_ss_sync  <= {r_ss_sync[SYNC_STAGES-2:0], i_ss_n};
            r_sio_sync <= {r_sio_sync[SYNC_STAGES-2:0], i_sio};
            r_sck_d    <= r_sck_sync[SYNC_STAGES-1];
            r_ss_d     <= r_ss_sync[SYNC_STAGES-1];
        end
    end

    assign o_sck_rise = r_sck_sync[SYNC_STAGES-1] & ~r_sck_d;
    assign o_sck_fall = ~r_sck_sync[SYNC_STAGES-1] & r_sck_d;
    assign o_ss_n     = r_ss_sync[SYNC_STAGES-1];
    assign o_ss_rise  = r_ss_sync[SYNC_STAGES-1] & ~r_ss_d;
    assign o_sio      = r_sio_sync[SYNC_STAGES-1];

endmodule

// File: rtl/qspi_sram_emu.sv
// Serial SRAM emulator: single and quad SPI read/write into a byte array,
// oversampling sck with the system clock.
module qspi_sram_emu
    import qspi_pkg::*;
#(
    parameter int ADDR_BITS   = 24,
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_CYCLES = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       ss_n,
    input  logic [3:0] sio_in,
    output logic [3:0] sio_out,
    output logic [3:0] sio_oe,
    output logic       cmd_error
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [4:0] ADDR_LAST = 5'(ADDR_BITS - 1);
    localparam logic [4:0] NIB_LAST  = 5'(ADDR_BITS / 4 - 1);
    localparam logic [4:0] WAIT_LAST = 5'(WAIT_CYCLES - 1);
    localparam logic [4:0] FAST_LAST = 5'(DUMMY_FAST - 1);

    logic                  w_sck_rise, w_sck_fall, w_ss_n, w_ss_rise;
    logic                  w_rise, w_fall, w_phase_end, w_mem_we;
    logic [3:0]            w_sio, w_oe_nxt;
    logic [4:0]            w_wait_last;
    logic [7:0]            w_cmd, w_wdata;
    logic [DEPTH_LOG2-1:0] w_addr_s1, w_addr_s4, w_addr_inc, w_pf_addr;
    state_t                r_state, w_state_nxt;
    logic [4:0]            r_cnt;
    logic [7:0]            r_cmd, r_data;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [3:0]            r_sio_out, r_sio_oe;
    logic                  r_cmd_error;
    logic [7:0]            r_mem [DEPTH];

    qspi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_sck      (sck),
        .i_ss_n     (ss_n),
        .i_sio      (sio_in),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_ss_n     (w_ss_n),
        .o_ss_rise  (w_ss_rise),
        .o_sio      (w_sio)
    );

    assign w_rise      = w_sck_rise & ~w_ss_n;
    assign w_fall      = w_sck_fall & ~w_ss_n;
    assign w_cmd       = {r_cmd[6:0], w_sio[0]};
    // Address bits shift straight into r_addr; bits above DEPTH_LOG2 fall off the top
    assign w_addr_s1   = DEPTH_LOG2'({r_addr, w_sio[0]});
    assign w_addr_s4   = DEPTH_LOG2'({r_addr, w_sio});
    assign w_addr_inc  = r_addr + DEPTH_LOG2'(1);
    assign w_pf_addr   = (r_state == ST_WAIT) ? r_addr :
                         (r_state == ST_ADDR_QUAD) ? w_addr_s4 : w_addr_s1;
    assign w_wdata     = (r_state == ST_WRITE_QUAD) ? {r_data[3:0], w_sio} : {r_data[6:0], w_sio[0]};
    assign w_wait_last = (r_cmd == OP_FAST_READ) ? FAST_LAST : WAIT_LAST;

    // Next-state decode, phase completion, memory write strobe and next output enable
    always_comb begin
        w_state_nxt = r_state;
        w_phase_end = 1'b0;
        w_mem_we    = 1'b0;
        w_oe_nxt    = 4'b0000;
        if (w_ss_rise) begin
            w_state_nxt = ST_COMMAND;
        end else if (w_rise) begin
            case (r_state)
                ST_COMMAND: begin
                    if (r_cnt == 5'd7) begin
                        w_phase_end = 1'b1;
                        w_state_nxt = decode_cmd(w_cmd);
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_ADDR: begin
                    if (r_cnt == ADDR_LAST) begin
                        w_phase_end = 1'b1;
                        if (r_cmd == OP_WRITE)          w_state_nxt = ST_WRITE;
                        else if (r_cmd == OP_FAST_READ) w_state_nxt = ST_WAIT;
                        else                            w_state_nxt = ST_READ;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_ADDR_QUAD: begin
                    if (r_cnt == NIB_LAST) begin
                        w_phase_end = 1'b1;
                        if (r_cmd == OP_QUAD_WRITE) w_state_nxt = ST_WRITE_QUAD;
                        else if (WAIT_CYCLES == 0)  w_state_nxt = ST_READ_QUAD;
                        else                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == w_wait_last) begin
                        w_phase_end = 1'b1;
                        w_state_nxt = (r_cmd == OP_FAST_READ) ? ST_READ : ST_READ_QUAD;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_WRITE:      w_mem_we = (r_cnt == 5'd7);
                ST_WRITE_QUAD: w_mem_we = (r_cnt == 5'd1);
                default:       w_state_nxt = r_state;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
        case (w_state_nxt)
            ST_READ:      w_oe_nxt = 4'b0010;
            ST_READ_QUAD: w_oe_nxt = 4'b1111;
            default:      w_oe_nxt = 4'b0000;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_COMMAND;
        else     r_state <= w_state_nxt;
    end

    // Shift registers, counters, address pointer and registered pin drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 5'd0;
            r_cmd       <= 8'h00;
            r_data      <= 8'h00;
            r_addr      <= '0;
            r_sio_out   <= 4'b0000;
            r_sio_oe    <= 4'b0000;
            r_cmd_error <= 1'b0;
        end else begin
            r_sio_oe <= w_oe_nxt;
            if (w_state_nxt == ST_FAIL) r_cmd_error <= 1'b1;
            if (w_ss_rise) begin
                r_cnt     <= 5'd0;
                r_sio_out <= 4'b0000;
            end else begin
                case (r_state)
                    ST_COMMAND: if (w_rise) begin
                        r_cmd <= w_cmd;
                        r_cnt <= w_phase_end ? 5'd0 : r_cnt + 5'd1;
                    end
                    ST_ADDR: if (w_rise) begin
                        r_addr <= w_addr_s1;
                        r_cnt  <= w_phase_end ? 5'd0 : r_cnt + 5'd1;
                    end
                    ST_ADDR_QUAD: if (w_rise) begin
                        r_addr <= w_addr_s4;
                        r_cnt  <= w_phase_end ? 5'd0 : r_cnt + 5'd1;
                    end
                    ST_WAIT: if (w_rise) begin
                        r_cnt <= w_phase_end ? 5'd0 : r_cnt + 5'd1;
                    end
                    ST_READ: if (w_fall) begin
                        r_sio_out <= {2'b00, r_data[7], 1'b0};
                        if (r_cnt == 5'd7) begin
                            r_cnt  <= 5'd0;
                            r_addr <= w_addr_inc;
                            r_data <= r_mem[w_addr_inc];
                        end else begin
                            r_cnt  <= r_cnt + 5'd1;
                            r_data <= {r_data[6:0], 1'b0};
                        end
                    end
                    ST_READ_QUAD: if (w_fall) begin
                        r_sio_out <= r_data[7:4];
                        if (r_cnt == 5'd1) begin
                            r_cnt  <= 5'd0;
                            r_addr <= w_addr_inc;
                            r_data <= r_mem[w_addr_inc];
                        end else begin
                            r_cnt  <= r_cnt + 5'd1;
                            r_data <= {r_data[3:0], 4'h0};
                        end
                    end
                    ST_WRITE, ST_WRITE_QUAD: if (w_rise) begin
                        r_data <= w_wdata;
                        if (w_mem_we) begin
                            r_cnt  <= 5'd0;
                            r_addr <= w_addr_inc;
                        end else begin
                            r_cnt  <= r_cnt + 5'd1;
                        end
                    end
                    default: r_cnt <= r_cnt;
                endcase
                // Prefetch so the first data bit is ready at the next falling edge
                if (w_phase_end && (w_state_nxt == ST_READ || w_state_nxt == ST_READ_QUAD))
                    r_data <= r_mem[w_pf_addr];
            end
        end
    end

    // Byte array; deliberately outside reset so contents survive rst
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_addr] <= w_wdata;
    end

    assign sio_out   = r_sio_out;
    assign sio_oe    = r_sio_oe;
    assign cmd_error = r_cmd_error;

endmodule

// File: tb/tb_qspi_sram_emu.sv
// Self-checking bench for qspi_sram_emu: directed scenarios plus randomized
// transactions checked against a byte-array memory model.
module tb_qspi_sram_emu;

    localparam int HALF = 60;
    typedef logic [7:0] bytes_t [$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       ss_n = 1'b1;
    logic [3:0] sio_in = 4'h0;
    logic [3:0] sio_out, sio_oe;
    logic       cmd_error;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] model_mem [4096];

    qspi_sram_emu dut (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .ss_n      (ss_n),
        .sio_in    (sio_in),
        .sio_out   (sio_out),
        .sio_oe    (sio_oe),
        .cmd_error (cmd_error)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // one sck period: drive, sample just before the rising edge, rise, fall
    task automatic xfer(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
        sio_in = d;
        #(HALF);
        q  = sio_out;
        oe = sio_oe;
        sck = 1'b1;
        #(HALF);
        sck = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int nbits, input bit quad, inout logic [3:0] oe_acc);
        logic [3:0] q, oe;
        if (quad) begin
            for (int i = nbits / 4 - 1; i >= 0; i--) begin
                xfer(v[i*4 +: 4], q, oe);
                oe_acc = oe_acc | oe;
            end
        end else begin
            for (int i = nbits - 1; i >= 0; i--) begin
                xfer({3'b000, v[i]}, q, oe);
                oe_acc = oe_acc | oe;
            end
        end
    endtask

    task automatic spi_begin();
        ss_n = 1'b0;
        #(HALF);
    endtask

    task automatic spi_end();
        sio_in = 4'h0;
        #(HALF);
        ss_n = 1'b1;
        #(2 * HALF);
    endtask

    task automatic write_txn(input logic [7:0] op, input logic [23:0] addr, input bytes_t d);
        logic [3:0] oe = 4'h0;
        bit quad = (op == 8'h38);
        spi_begin();
        send_bits({24'h0, op}, 8, 1'b0, oe);
        send_bits({8'h0, addr}, 24, quad, oe);
        foreach (d[k]) send_bits({24'h0, d[k]}, 8, quad, oe);
        spi_end();
        foreach (d[k]) model_mem[(int'(addr) + k) % 4096] = d[k];
    endtask

    task automatic read_txn(input logic [7:0] op, input logic [23:0] addr, input int n,
                            output bytes_t q, output logic [3:0] idle_oe, output logic [3:0] data_oe);
        logic [3:0] s, oe;
        logic [7:0] b;
        bit quad = (op == 8'hEB);
        int ndummy = (op == 8'h0B) ? 8 : (op == 8'hEB) ? 4 : 0;
        q = {};
        idle_oe = 4'h0;
        data_oe = 4'h0;
        spi_begin();
        send_bits({24'h0, op}, 8, 1'b0, idle_oe);
        send_bits({8'h0, addr}, 24, quad, idle_oe);
        for (int i = 0; i < ndummy; i++) begin
            xfer(4'h0, s, oe);
            idle_oe = idle_oe | oe;
        end
        for (int k = 0; k < n; k++) begin
            b = 8'h00;
            if (quad) begin
                xfer(4'h0, s, oe); b[7:4] = s; data_oe = data_oe | oe;
                xfer(4'h0, s, oe); b[3:0] = s; data_oe = data_oe | oe;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    xfer(4'h0, s, oe);
                    b = {b[6:0], s[1]};
                    data_oe = data_oe | oe;
                end
            end
            q.push_back(b);
        end
        spi_end();
    endtask

    task automatic test_reset();
        if (sio_out !== 4'h0) begin $display("FAIL reset_sio_out: got %h want %h", sio_out, 4'h0); n_fail++; end
        n_checks++;
        if (sio_oe !== 4'h0) begin $display("FAIL reset_sio_oe: got %h want %h", sio_oe, 4'h0); n_fail++; end
        n_checks++;
        if (cmd_error !== 1'b0) begin $display("FAIL reset_cmd_error: got %b want %b", cmd_error, 1'b0); n_fail++; end
        n_checks++;
        rst = 1'b0;
        #(2 * HALF);
    endtask

    task automatic test_write_read();
        bytes_t q;
        logic [3:0] ioe, doe;
        write_txn(8'h02, 24'h000010, '{8'hA5, 8'h3C});
        read_txn(8'h03, 24'h000010, 2, q, ioe, doe);
        if (q[0] !== 8'hA5) begin $display("FAIL wr_rd_byte0: got %h want %h", q[0], 8'hA5); n_fail++; end
        n_checks++;
        if (q[1] !== 8'h3C) begin $display("FAIL wr_rd_byte1: got %h want %h", q[1], 8'h3C); n_fail++; end
        n_checks++;
        if (doe !== 4'b0010) begin $display("FAIL wr_rd_data_oe: got %b want %b", doe, 4'b0010); n_fail++; end
        n_checks++;
        if (ioe !== 4'b0000) begin $display("FAIL wr_rd_idle_oe: got %b want %b", ioe, 4'b0000); n_fail++; end
        n_checks++;
    endtask

    task automatic test_quad();
        bytes_t q;
        logic [3:0] ioe, doe;
        write_txn(8'h38, 24'h000FFF, '{8'h11, 8'h22});
        read_txn(8'hEB, 24'h000FFF, 2, q, ioe, doe);
        if (q[0] !== 8'h11) begin $display("FAIL quad_byte0: got %h want %h", q[0], 8'h11); n_fail++; end
        n_checks++;
        if (q[1] !== 8'h22) begin $display("FAIL quad_byte1_wrap: got %h want %h", q[1], 8'h22); n_fail++; end
        n_checks++;
        if (doe !== 4'b1111) begin $display("FAIL quad_data_oe: got %b want %b", doe, 4'b1111); n_fail++; end
        n_checks++;
        if (ioe !== 4'b0000) begin $display("FAIL quad_idle_oe: got %b want %b", ioe, 4'b0000); n_fail++; end
        n_checks++;
        read_txn(8'h03, 24'h000000, 1, q, ioe, doe);
        if (q[0] !== 8'h22) begin $display("FAIL quad_wrap_addr0: got %h want %h", q[0], 8'h22); n_fail++; end
        n_checks++;
    endtask

    task automatic test_fast_read();
        bytes_t q;
        logic [3:0] ioe, doe;
        read_txn(8'h0B, 24'h000010, 1, q, ioe, doe);
        if (q[0] !== 8'hA5) begin $display("FAIL fast_byte: got %h want %h", q[0], 8'hA5); n_fail++; end
        n_checks++;
        if (ioe !== 4'b0000) begin $display("FAIL fast_dummy_oe: got %b want %b", ioe, 4'b0000); n_fail++; end
        n_checks++;
    endtask

    task automatic test_bad_opcode();
        bytes_t q;
        logic [3:0] oe = 4'h0, ioe, doe;
        spi_begin();
        send_bits(32'h9F, 8, 1'b0, oe);
        if (cmd_error !== 1'b1) begin $display("FAIL bad_op_flag: got %b want %b", cmd_error, 1'b1); n_fail++; end
        n_checks++;
        oe = 4'h0;
        send_bits(32'h03000010, 32, 1'b0, oe);
        if (oe !== 4'b0000) begin $display("FAIL bad_op_oe: got %b want %b", oe, 4'b0000); n_fail++; end
        n_checks++;
        spi_end();
        if (sio_oe !== 4'b0000) begin $display("FAIL bad_op_oe_after: got %b want %b", sio_oe, 4'b0000); n_fail++; end
        n_checks++;
        if (cmd_error !== 1'b1) begin $display("FAIL bad_op_sticky: got %b want %b", cmd_error, 1'b1); n_fail++; end
        n_checks++;
        read_txn(8'h03, 24'h000010, 1, q, ioe, doe);
        if (q[0] !== 8'hA5) begin $display("FAIL bad_op_recover: got %h want %h", q[0], 8'hA5); n_fail++; end
        n_checks++;
    endtask

    task automatic test_abort();
        bytes_t q;
        logic [3:0] oe = 4'h0, ioe, doe;
        spi_begin();
        send_bits(32'h02, 8, 1'b0, oe);
        send_bits(32'h000010, 24, 1'b0, oe);
        send_bits(32'h5, 4, 1'b0, oe);
        spi_end();
        read_txn(8'h03, 24'h000010, 1, q, ioe, doe);
        if (q[0] !== 8'hA5) begin $display("FAIL abort_mem_kept: got %h want %h", q[0], 8'hA5); n_fail++; end
        n_checks++;
    endtask

    task automatic test_random();
        bytes_t d, q;
        logic [3:0] ioe, doe, exp_oe;
        logic [23:0] addr;
        logic [7:0] wop, rop;
        int len, sel;
        for (int t = 0; t < 6; t++) begin
            addr = 24'($urandom);
            len  = int'($urandom_range(1, 4));
            wop  = ($urandom_range(0, 1) == 0) ? 8'h02 : 8'h38;
            d = {};
            for (int k = 0; k < len; k++) d.push_back(8'($urandom));
            write_txn(wop, addr, d);
            sel = int'($urandom_range(0, 2));
            rop = (sel == 0) ? 8'h03 : (sel == 1) ? 8'h0B : 8'hEB;
            exp_oe = (rop == 8'hEB) ? 4'b1111 : 4'b0010;
            read_txn(rop, addr, len, q, ioe, doe);
            for (int k = 0; k < len; k++) begin
                if (q[k] !== model_mem[(int'(addr) + k) % 4096]) begin
                    $display("FAIL rand_data t%0d op%h k%0d: got %h want %h", t, rop, k, q[k],
                             model_mem[(int'(addr) + k) % 4096]);
                    n_fail++;
                end
                n_checks++;
            end
            if (doe !== exp_oe) begin $display("FAIL rand_oe t%0d: got %b want %b", t, doe, exp_oe); n_fail++; end
            n_checks++;
        end
    endtask

    task automatic test_rst_mid_read();
        bytes_t q;
        logic [3:0] oe = 4'h0, s, ioe, doe;
        spi_begin();
        send_bits(32'hEB, 8, 1'b0, oe);
        send_bits(32'h000010, 24, 1'b1, oe);
        for (int i = 0; i < 4; i++) xfer(4'h0, s, oe);
        xfer(4'h0, s, oe);
        @(negedge clk);
        rst = 1'b1;
        #1;
        if (sio_oe !== 4'b0000) begin $display("FAIL rst_mid_oe: got %b want %b", sio_oe, 4'b0000); n_fail++; end
        n_checks++;
        if (cmd_error !== 1'b0) begin $display("FAIL rst_mid_cmd_error: got %b want %b", cmd_error, 1'b0); n_fail++; end
        n_checks++;
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        ss_n = 1'b1;
        sck  = 1'b0;
        #(2 * HALF);
        read_txn(8'h03, 24'h000010, 2, q, ioe, doe);
        for (int k = 0; k < 2; k++) begin
            if (q[k] !== model_mem[16 + k]) begin
                $display("FAIL rst_mid_mem k%0d: got %h want %h", k, q[k], model_mem[16 + k]);
                n_fail++;
            end
            n_checks++;
        end
    endtask

    initial begin
        #(50);
        @(negedge clk);
        test_reset();
        test_write_read();
        test_quad();
        test_fast_read();
        test_bad_opcode();
        test_abort();
        test_random();
        test_rst_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
